proc_commit_checker: RTL and testbench

- Synthesizable, parametrised successor to the processor bench's end-of-run register check. It snoops the regfile write port for a fixed cycle budget, then sweeps a loaded table of expected register values against a shadow copy.
- Reports pass/fail, a saturating error count and details of the first mismatch.
- Sits beside the processor and skeleton regfile, so on-board self-tests and simulation share one checker.

---
 rtl/proc_check_pkg.sv | 14 +
 rtl/chk_reg_table.sv | 31 +++
 rtl/proc_commit_checker.sv | 151 +++++++++++++++
 tb/tb_proc_commit_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_check_pkg.sv
// Shared types and default sizes for the commit checker and skeleton regfile.
package proc_check_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/chk_reg_table.sv
// Register-indexed table: one synchronous write port, one combinational read.
module chk_reg_table #(
  parameter int NUM = 32,
  parameter int W   = 33,
  parameter int AW  = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [NUM];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/proc_commit_checker.sv
// Snoops regfile writes for a fixed run window, then sweeps the shadow
// against an expected table and reports pass/fail with first-mismatch info.
module proc_commit_checker
  import proc_check_pkg::*;
#(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CYCLE_LIMIT = 1000,
  parameter int CNT_W       = 16,
  parameter int ERR_W       = 8,
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              ctrl_writeEnable,
  input  logic [IDX_W-1:0]  ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic              exp_wr_en,
  input  logic [IDX_W-1:0]  exp_wr_addr,
  input  logic [DATA_W-1:0] exp_wr_data,
  input  logic              exp_wr_check,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic              first_err_valid,
  output logic [IDX_W-1:0]  first_err_reg,
  output logic [DATA_W-1:0] first_err_expected,
  output logic [DATA_W-1:0] first_err_read,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  write_count
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [DATA_W:0]  exp_rd;
  logic [DATA_W:0]  sh_rd;
  logic             idle_like;
  logic             go;
  logic             sh_we;
  logic             hit;
  logic             last;
  logic             cyc_last;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign go        = start && idle_like;
  assign sh_we     = (state == RUN) && ctrl_writeEnable
                     && (ctrl_writeReg != '0);
  assign last      = idx == IDX_W'(NUM_REGS - 1);
  assign cyc_last  = cycle_count == CNT_W'(CYCLE_LIMIT - 1);

  // Shadow entries keep their top bit at 0, so a full-width compare
  // against {0, expected} is a pure data compare.
  assign hit = exp_rd[DATA_W]
               && (sh_rd != {1'b0, exp_rd[DATA_W-1:0]});

  chk_reg_table #(
    .NUM (NUM_REGS),
    .W   (DATA_W + 1),
    .AW  (IDX_W)
  ) u_exp (
    .clock   (clock),
    .reset   (reset),
    .clr     (1'b0),
    .wr_en   (exp_wr_en && idle_like),
    .wr_addr (exp_wr_addr),
    .wr_data ({exp_wr_check, exp_wr_data}),
    .rd_addr (idx),
    .rd_data (exp_rd)
  );

  chk_reg_table #(
    .NUM (NUM_REGS),
    .W   (DATA_W + 1),
    .AW  (IDX_W)
  ) u_shadow (
    .clock   (clock),
    .reset   (reset),
    .clr     (go),
    .wr_en   (sh_we),
    .wr_addr (ctrl_writeReg),
    .wr_data ({1'b0, data_writeReg}),
    .rd_addr (idx),
    .rd_data (sh_rd)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      idx                <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      error_count        <= '0;
      first_err_valid    <= 1'b0;
      first_err_reg      <= '0;
      first_err_expected <= '0;
      first_err_read     <= '0;
      cycle_count        <= '0;
      write_count        <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state              <= RUN;
            idx                <= '0;
            busy               <= 1'b1;
            done               <= 1'b0;
            pass               <= 1'b0;
            error_count        <= '0;
            first_err_valid    <= 1'b0;
            first_err_reg      <= '0;
            first_err_expected <= '0;
            first_err_read     <= '0;
            cycle_count        <= '0;
            write_count        <= '0;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + 1'b1;
          if (sh_we && (write_count != '1))
            write_count <= write_count + 1'b1;
          if (cyc_last)
            state <= CHECK;
        end
        CHECK: begin
          if (hit) begin
            if (error_count != '1)
              error_count <= error_count + 1'b1;
            if (!first_err_valid) begin
              first_err_valid    <= 1'b1;
              first_err_reg      <= idx;
              first_err_expected <= exp_rd[DATA_W-1:0];
              first_err_read     <= sh_rd[DATA_W-1:0];
            end
          end
          idx <= idx + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (error_count == '0) && !hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_commit_checker.sv
// Directed scoreboard bench for proc_commit_checker (CYCLE_LIMIT=20, ERR_W=2).
`timescale 1ns/1ps
module tb_proc_commit_checker;

  localparam int L = 20;
  localparam int N = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        exp_wr_en;
  logic [4:0]  exp_wr_addr;
  logic [31:0] exp_wr_data;
  logic        exp_wr_check;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  error_count;
  logic        first_err_valid;
  logic [4:0]  first_err_reg;
  logic [31:0] first_err_expected;
  logic [31:0] first_err_read;
  logic [15:0] cycle_count;
  logic [15:0] write_count;

  proc_commit_checker #(
    .NUM_REGS    (N),
    .DATA_W      (32),
    .CYCLE_LIMIT (L),
    .CNT_W       (16),
    .ERR_W       (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .ctrl_writeEnable   (ctrl_writeEnable),
    .ctrl_writeReg      (ctrl_writeReg),
    .data_writeReg      (data_writeReg),
    .exp_wr_en          (exp_wr_en),
    .exp_wr_addr        (exp_wr_addr),
    .exp_wr_data        (exp_wr_data),
    .exp_wr_check       (exp_wr_check),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .error_count        (error_count),
    .first_err_valid    (first_err_valid),
    .first_err_reg      (first_err_reg),
    .first_err_expected (first_err_expected),
    .first_err_read     (first_err_read),
    .cycle_count        (cycle_count),
    .write_count        (write_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int r;
    int d;
  } wr_t;

  typedef struct {
    logic ps;
    int   ec;
    logic fv;
    int   fr;
    int   fe;
    int   fd;
    int   wc;
  } res_t;

  wr_t  wq[$];
  res_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   ew_cyc = -1;
  int   ew_addr = 0;
  int   ew_data = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic load(input int a, input int d, input logic c);
    @(negedge clock);
    exp_wr_en    = 1'b1;
    exp_wr_addr  = 5'(a);
    exp_wr_data  = 32'(d);
    exp_wr_check = c;
    @(negedge clock);
    exp_wr_en = 1'b0;
  endtask

  task automatic wr(input int c, input int r, input int d);
    wr_t w;
    w.cyc = c;
    w.r   = r;
    w.d   = d;
    wq.push_back(w);
  endtask

  task automatic expect_res(input logic ps, input int ec, input logic fv,
                            input int fr, input int fe, input int fd,
                            input int wc);
    res_t e;
    e.ps = ps; e.ec = ec; e.fv = fv;
    e.fr = fr; e.fe = fe; e.fd = fd; e.wc = wc;
    sbq.push_back(e);
  endtask

  // c equals the DUT cycle_count during RUN; c == L is the first CHECK cycle.
  task automatic run_check();
    time  t0;
    int   n;
    res_t e;
    @(negedge clock);
    start = 1'b1;
    t0 = $time;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c <= L; c++) begin
      ctrl_writeEnable = 1'b0;
      foreach (wq[k]) begin
        if (wq[k].cyc == c) begin
          ctrl_writeEnable = 1'b1;
          ctrl_writeReg    = 5'(wq[k].r);
          data_writeReg    = 32'(wq[k].d);
        end
      end
      exp_wr_en    = (c == ew_cyc);
      exp_wr_addr  = 5'(ew_addr);
      exp_wr_data  = 32'(ew_data);
      exp_wr_check = 1'b1;
      @(negedge clock);
    end
    ctrl_writeEnable = 1'b0;
    exp_wr_en = 1'b0;
    wq.delete();
    ew_cyc = -1;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("done", 64'(done), 64'd1);
    chk("latency", 64'(($time - t0) / 10), 64'(1 + L + N));
    chk("cycle_count", 64'(cycle_count), 64'(L));
    chk("busy_done", 64'(busy), 64'd0);
    e = sbq.pop_front();
    chk("pass", 64'(pass), 64'(e.ps));
    chk("error_count", 64'(error_count), 64'(e.ec));
    chk("first_err_valid", 64'(first_err_valid), 64'(e.fv));
    chk("first_err_reg", 64'(first_err_reg), 64'(e.fr));
    chk("first_err_expected", 64'(first_err_expected), 64'(e.fe));
    chk("first_err_read", 64'(first_err_read), 64'(e.fd));
    chk("write_count", 64'(write_count), 64'(e.wc));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg = '0;
    data_writeReg = '0;
    exp_wr_en = 1'b0;
    exp_wr_addr = '0;
    exp_wr_data = '0;
    exp_wr_check = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_errs", 64'(error_count), 64'd0);
    chk("rst_fev", 64'(first_err_valid), 64'd0);
    chk("rst_cyc", 64'(cycle_count), 64'd0);
    chk("rst_wc", 64'(write_count), 64'd0);
    reset = 1'b1;

    // matching writes
    load(1, 5, 1'b1);
    load(2, 10, 1'b1);
    wr(2, 1, 5);
    wr(5, 2, 10);
    expect_res(1'b1, 0, 1'b0, 0, 0, 0, 2);
    run_check();

    // single mismatch on r2
    wr(2, 1, 5);
    wr(6, 2, 11);
    expect_res(1'b0, 1, 1'b1, 2, 10, 11, 2);
    run_check();

    // r0 writes dropped and uncounted
    load(0, 0, 1'b1);
    wr(1, 0, 7);
    wr(3, 1, 5);
    wr(4, 2, 10);
    expect_res(1'b1, 0, 1'b0, 0, 0, 0, 2);
    run_check();

    // write in final RUN cycle is captured
    load(3, 9, 1'b1);
    wr(0, 1, 5);
    wr(1, 2, 10);
    wr(L - 1, 3, 9);
    expect_res(1'b1, 0, 1'b0, 0, 0, 0, 3);
    run_check();

    // write one cycle into CHECK is ignored
    wr(0, 1, 5);
    wr(1, 2, 10);
    wr(L, 3, 9);
    expect_res(1'b0, 1, 1'b1, 3, 9, 0, 2);
    run_check();

    // five mismatches saturate a 2-bit counter
    for (int i = 4; i <= 8; i++) load(i, 100 + i, 1'b1);
    wr(0, 1, 5);
    wr(1, 2, 10);
    wr(2, 3, 9);
    for (int i = 4; i <= 8; i++) wr(i, i, 200 + i);
    expect_res(1'b0, 3, 1'b1, 4, 104, 204, 8);
    run_check();

    // reset in mid-RUN
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd1;
    data_writeReg = 32'd5;
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_wc", 64'(write_count), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_cyc", 64'(cycle_count), 64'd0);
    chk("mrst_wc", 64'(write_count), 64'd0);
    chk("mrst_fev", 64'(first_err_valid), 64'd0);
    reset = 1'b1;

    // check bits cleared by reset: bad values are not flagged
    wr(0, 2, 11);
    wr(1, 4, 1);
    expect_res(1'b1, 0, 1'b0, 0, 0, 0, 2);
    run_check();

    // table write during RUN is dropped
    load(1, 5, 1'b1);
    ew_cyc = 3;
    ew_addr = 1;
    ew_data = 99;
    wr(0, 1, 5);
    expect_res(1'b1, 0, 1'b0, 0, 0, 0, 1);
    run_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
